mux_2x1_arbiter: RTL and testbench
==================================

Name: mux_2x1_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 2:1 one-bit mux path between requester 0 (data a) and requester 1 (data b).
- Owns the mux select and registers the selected bit onto a single shared output line with a valid flag.
- Bounds each grant to MAX_HOLD cycles when the other side is waiting.
- Sits between the two producers and the shared downstream line.

Parameters:
- MAX_HOLD, 4: maximum consecutive granted cycles while the other requester is waiting; legal range 1..255.
- CNT_W, 8: width of the internal hold counter; must hold MAX_HOLD-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 wants the shared line.
- req1  input  1  requester 1 wants the shared line.
- a  input  1  data bit from requester 0.
- b  input  1  data bit from requester 1.
- gnt0  output  1  requester 0 owns the line this cycle (registered).
- gnt1  output  1  requester 1 owns the line this cycle (registered).
- sel  output  1  mux select: 0 = a, 1 = b.
- out  output  1  registered shared data bit.
- out_valid  output  1  out carries granted data.

Behaviour:
- States: IDLE, GRANT0, GRANT1. Outputs decode from state:
  - gnt0 = (state == GRANT0); gnt1 = (state == GRANT1).
  - sel = 1 only in GRANT1; 0 in IDLE and GRANT0.
- Internal registers: hold_cnt (CNT_W bits) and last (1 bit, last requester granted).
- Reset (reset_n = 0, takes effect immediately, no clock needed, including mid-grant):
  - state = IDLE; gnt0 = gnt1 = 0; sel = 0; out = 0; out_valid = 0.
  - hold_cnt = 0; last = 1, so requester 0 wins the first conflict.
- Request-to-grant latency: 1 clock. A req sampled high at edge N gives gnt high after edge N.
- IDLE transitions:
  - Only req0: go to GRANT0.
  - Only req1: go to GRANT1.
  - Both: grant the requester != last.
  - Neither: stay in IDLE.
- On every grant entry: hold_cnt <= 0 and last <= granted index.
- GRANTx, own reqx low: release.
  - Next state is GRANTy if reqy is high (direct handover, no IDLE bubble); else IDLE.
- GRANTx, reqx high, reqy high, hold_cnt == MAX_HOLD-1: forced switch to GRANTy. Total granted cycles for x = MAX_HOLD.
- GRANTx, reqx high, otherwise:
  - Stay in GRANTx; hold_cnt <= hold_cnt + 1.
  - hold_cnt saturates at MAX_HOLD-1 when reqy is low, so ownership is unlimited while uncontended.
  - If reqy rises later, the switch occurs at the first edge where reqy is high and hold_cnt == MAX_HOLD-1.
- Data path, each edge:
  - out <= (sel ? b : a), sampled combinationally through the mux in the current state.
  - out_valid <= gnt0 | gnt1.
  - out and out_valid therefore lag the grant by exactly 1 cycle.
  - When not valid, out still follows the mux (a, since sel = 0); consumers ignore it.
- MAX_HOLD = 1 with both requesting: grant alternates every cycle.
- gnt0 and gnt1 are never high together, including across a handover.
- last is not modified by reset release or IDLE.

Test Plan:
- Reset then idle: reset_n = 0 for 2 cycles with req0 = req1 = 1 → gnt0 = gnt1 = sel = out = out_valid = 0. Release → gnt0 = 1 one edge later, since last = 1.
- Single requester: req0 = 1 for 6 cycles, a toggling 1,0,1,1,0,1, req1 = 0 → gnt0 high 6 cycles; out reproduces the a sequence delayed 1 cycle; out_valid high 6 cycles; no forced switch.
- Contention, MAX_HOLD = 4, req0 = req1 = 1 held → gnt pattern 0,0,0,0,1,1,1,1,0… with sel matching; out = a for 4 cycles, then b for 4, each 1-cycle delayed.
- Handover: in GRANT1, drop req1 while req0 = 1 → next edge gnt1 = 0 and gnt0 = 1 (no IDLE cycle); out_valid stays 1 continuously.
- Round robin from IDLE: grant 0 completes (last = 0), both idle, then req0 = req1 = 1 in the same cycle → GRANT1 wins.
- Async reset mid-grant: in GRANT1 with hold_cnt = 2, pulse reset_n low between edges → outputs clear immediately without a clock. After release with req0 = req1 = 1 → GRANT0.

Source files
------------

// File: rtl/mux_2x1_arbiter_if.sv
// Shared-line bundle between two one-bit producers and the round-robin 2:1 arbiter.
// The master side drives requests/data; the slave (arbiter) returns grants, select and the registered line.
interface mux_2x1_arbiter_if;
  logic req0;
  logic req1;
  logic a;
  logic b;
  logic gnt0;
  logic gnt1;
  logic sel;
  logic out;
  logic out_valid;

  modport master (
    output req0, req1, a, b,
    input  gnt0, gnt1, sel, out, out_valid
  );

  modport slave (
    input  req0, req1, a, b,
    output gnt0, gnt1, sel, out, out_valid
  );
endinterface

// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter owning a 2:1 one-bit mux; grants are bounded to MAX_HOLD cycles under contention
// and the selected bit is registered onto the shared line one cycle behind the grant.
module mux_2x1_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input logic              clk,
  input logic              reset_n,
  mux_2x1_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [CNT_W-1:0] next_hold_s;
  logic             last_r;
  logic             next_last_s;
  logic             gnt0_r;
  logic             gnt1_r;
  logic             sel_r;
  logic             out_r;
  logic             out_valid_r;

  // Next-state selection: release, forced switch at the hold limit, or round-robin tie-break from idle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          next_state_s = last_r ? GRANT0 : GRANT1;
        end else if (bus.req0) begin
          next_state_s = GRANT0;
        end else if (bus.req1) begin
          next_state_s = GRANT1;
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT0: begin
        if (!bus.req0) begin
          next_state_s = bus.req1 ? GRANT1 : IDLE;
        end else if (bus.req1 && (hold_cnt_r == HOLD_LAST)) begin
          next_state_s = GRANT1;
        end else begin
          next_state_s = GRANT0;
        end
      end
      GRANT1: begin
        if (!bus.req1) begin
          next_state_s = bus.req0 ? GRANT0 : IDLE;
        end else if (bus.req0 && (hold_cnt_r == HOLD_LAST)) begin
          next_state_s = GRANT0;
        end else begin
          next_state_s = GRANT1;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Hold counter and last-winner bookkeeping; the counter saturates so an uncontended owner keeps the line.
  always_comb begin
    next_hold_s = hold_cnt_r;
    next_last_s = last_r;
    if ((next_state_s == GRANT0) && (state_r != GRANT0)) begin
      next_hold_s = {CNT_W{1'b0}};
      next_last_s = 1'b0;
    end else if ((next_state_s == GRANT1) && (state_r != GRANT1)) begin
      next_hold_s = {CNT_W{1'b0}};
      next_last_s = 1'b1;
    end else if ((next_state_s != IDLE) && (hold_cnt_r != HOLD_LAST)) begin
      next_hold_s = hold_cnt_r + CNT_W'(1);
    end else begin
      next_hold_s = hold_cnt_r;
    end
  end

  // State, grant decode and the registered data path (out follows the mux chosen by the current select).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      hold_cnt_r  <= {CNT_W{1'b0}};
      last_r      <= 1'b1;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      sel_r       <= 1'b0;
      out_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      hold_cnt_r  <= next_hold_s;
      last_r      <= next_last_s;
      gnt0_r      <= (next_state_s == GRANT0);
      gnt1_r      <= (next_state_s == GRANT1);
      sel_r       <= (next_state_s == GRANT1);
      out_r       <= sel_r ? bus.b : bus.a;
      out_valid_r <= gnt0_r | gnt1_r;
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.sel       = sel_r;
  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed bench for mux_2x1_arbiter: reset, contention, handover, round robin, async reset, single requester,
// plus a MAX_HOLD = 1 instance that must alternate every cycle.
module tb_mux_2x1_arbiter;

  logic clk;
  logic reset_n;
  int   passed;
  int   total;

  mux_2x1_arbiter_if bif ();
  mux_2x1_arbiter_if bif1 ();

  mux_2x1_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  mux_2x1_arbiter #(.MAX_HOLD(1), .CNT_W(8)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif1.slave)
  );

  logic [4:0] obs;
  logic [4:0] obs1;
  assign obs  = {bif.gnt0, bif.gnt1, bif.sel, bif.out, bif.out_valid};
  assign obs1 = {3'b000, bif1.gnt0, bif1.gnt1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, o, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic aseq [6];

  initial begin
    passed  = 0;
    total   = 0;
    aseq    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset_n = 1'b1;
    bif.req0 = 1'b1; bif.req1 = 1'b1; bif.a = 1'b1; bif.b = 1'b0;
    bif1.req0 = 1'b1; bif1.req1 = 1'b1; bif1.a = 1'b1; bif1.b = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk("reset_async", obs, 5'b00000);
    step();
    step();
    chk("reset_held", obs, 5'b00000);
    chk("reset_held_m1", obs1, 5'b00000);
    reset_n = 1'b1;

    // contention with MAX_HOLD = 4: four cycles of gnt0, four of gnt1, then back
    step(); chk("cont_e1", obs, 5'b10010); chk("m1_e1", obs1, 5'b00010);
    step(); chk("cont_e2", obs, 5'b10011); chk("m1_e2", obs1, 5'b00001);
    step(); chk("cont_e3", obs, 5'b10011); chk("m1_e3", obs1, 5'b00010);
    step(); chk("cont_e4", obs, 5'b10011); chk("m1_e4", obs1, 5'b00001);
    step(); chk("cont_e5", obs, 5'b01111);
    step(); chk("cont_e6", obs, 5'b01101);
    step(); chk("cont_e7", obs, 5'b01101);
    step(); chk("cont_e8", obs, 5'b01101);
    step(); chk("cont_e9", obs, 5'b10001);
    step(); chk("cont_e10", obs, 5'b10011);

    // handover 0 -> 1 and 1 -> 0 with no idle bubble
    bif.req0 = 1'b0; bif.req1 = 1'b1;
    step(); chk("handover_0to1", obs, 5'b01111);
    bif.req0 = 1'b1; bif.req1 = 1'b0;
    step(); chk("handover_1to0", obs, 5'b10001);

    // release to idle, then simultaneous requests go to requester 1 (last = 0)
    bif.req0 = 1'b0; bif.req1 = 1'b0; bif.a = 1'b0;
    step(); chk("release_idle", obs, 5'b00001);
    step(); chk("idle_quiet", obs, 5'b00000);
    bif.req0 = 1'b1; bif.req1 = 1'b1; bif.b = 1'b1;
    step(); chk("rr_from_idle", obs, 5'b01100);
    step(); chk("g1_hold1", obs, 5'b01111);
    step(); chk("g1_hold2", obs, 5'b01111);

    // async reset between edges, mid-grant
    #1 reset_n = 1'b0;
    #1 chk("reset_midgrant", obs, 5'b00000);
    #1 reset_n = 1'b1;
    step(); chk("post_reset_g0", obs, 5'b10000);

    // single requester: out replays a one cycle late, no forced switch past MAX_HOLD
    bif.req1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bif.a = aseq[i];
      step();
      chk($sformatf("single_%0d", i), obs, {3'b100, aseq[i], 1'b1});
    end

    // saturated counter: requester 1 arriving late takes over at the next edge
    bif.req1 = 1'b1;
    step(); chk("late_contender", obs, 5'b01111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
